bch_shared_kes_dispatcher: RTL and testbench

Shares one key-equation-solver (KES) engine among `Channels` BCH decoder channels, each handling `BCHDecMulti` chunks. The block sits between the decoder channels' syndrome/ELP ports and a single shared KES. It buffers one syndrome set per channel and grants the KES round-robin. Requests whose chunks need no decoding return a zero-error result directly, without occupying the KES.

---
 rtl/bch_kes_pkg.sv | 28 ++
 rtl/bch_rr_arbiter.sv | 32 +++
 rtl/bch_shared_kes_dispatcher.sv | 207 ++++++++++++++++++++
 tb/tb_bch_shared_kes_dispatcher.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_kes_pkg.sv
// Shared definitions for the BCH shared-KES dispatcher: default widths,
// derived request/result slice widths, the dispatcher FSM state type and
// the channel index width.
package bch_kes_pkg;

    localparam int CHANNELS            = 4;
    localparam int BCH_DEC_MULTI       = 2;
    localparam int GALOIS_FIELD_DEGREE = 12;
    localparam int MAX_ERROR_COUNT_BITS = 9;
    localparam int SYNDROMES           = 27;
    localparam int ELP_COEFFICIENTS    = 15;

    // One channel request: all chunks' syndromes.
    localparam int SYN_SLICE_W = BCH_DEC_MULTI * GALOIS_FIELD_DEGREE * SYNDROMES;
    // One channel result: all chunks' ELP coefficients and error counts.
    localparam int ELP_SLICE_W = BCH_DEC_MULTI * GALOIS_FIELD_DEGREE * ELP_COEFFICIENTS;
    localparam int CNT_SLICE_W = BCH_DEC_MULTI * MAX_ERROR_COUNT_BITS;

    localparam int CH_IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } kes_state_e;

endpackage

// File: rtl/bch_rr_arbiter.sv
// Round-robin search: first asserted request at or after ptr, wrapping.
// Ports: req (requests), ptr (search start) -> gnt (one-hot), gnt_idx, gnt_vld.
// Purely combinational; the pointer register lives in the caller.
module bch_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bch_shared_kes_dispatcher.sv
// Shares one KES engine among several BCH decoder channels. One syndrome set is
// buffered per channel; pending requests are granted round-robin. Requests with
// no chunk needing decoding return an all-zero result without touching the KES.
// Ports: iCh* syndrome/flag inputs and oCh* ready/result outputs per channel,
// oKES*/iKES* handshake to the shared KES, oBusy = FSM not idle.
module bch_shared_kes_dispatcher
    import bch_kes_pkg::*;
#(
    parameter int Channels          = CHANNELS,
    parameter int BCHDecMulti       = BCH_DEC_MULTI,
    parameter int GaloisFieldDegree = GALOIS_FIELD_DEGREE,
    parameter int MaxErrorCountBits = MAX_ERROR_COUNT_BITS,
    parameter int Syndromes         = SYNDROMES,
    parameter int ELPCoefficients   = ELP_COEFFICIENTS
) (
    input  logic                                                 iClock,
    input  logic                                                 iReset,
    input  logic [Channels*BCHDecMulti-1:0]                      iChErrorDetectionEnd,
    input  logic [Channels*BCHDecMulti-1:0]                      iChDecodeNeeded,
    input  logic [Channels*BCHDecMulti*GaloisFieldDegree*Syndromes-1:0] iChSyndromes,
    output logic [Channels-1:0]                                  oChSharedKESReady,
    input  logic [Channels-1:0]                                  iChCSAvailable,
    output logic [Channels-1:0]                                  oChIntraSharedKESEnd,
    output logic [Channels*BCHDecMulti-1:0]                      oChErroredChunk,
    output logic [Channels*BCHDecMulti-1:0]                      oChCorrectionFail,
    output logic [Channels*BCHDecMulti*MaxErrorCountBits-1:0]    oChErrorCount,
    output logic [Channels*BCHDecMulti*GaloisFieldDegree*ELPCoefficients-1:0] oChELPCoefficients,
    output logic                                                 oKESStart,
    output logic [BCHDecMulti-1:0]                               oKESDecodeNeeded,
    output logic [BCHDecMulti*GaloisFieldDegree*Syndromes-1:0]   oKESSyndromes,
    input  logic                                                 iKESReady,
    input  logic                                                 iKESDone,
    input  logic [BCHDecMulti-1:0]                               iKESErroredChunk,
    input  logic [BCHDecMulti-1:0]                               iKESCorrectionFail,
    input  logic [BCHDecMulti*MaxErrorCountBits-1:0]             iKESErrorCount,
    input  logic [BCHDecMulti*GaloisFieldDegree*ELPCoefficients-1:0] iKESELPCoefficients,
    output logic                                                 oBusy
);

    localparam int SynW = BCHDecMulti * GaloisFieldDegree * Syndromes;
    localparam int ElpW = BCHDecMulti * GaloisFieldDegree * ELPCoefficients;
    localparam int CntW = BCHDecMulti * MaxErrorCountBits;
    localparam int IdxW = (Channels > 1) ? $clog2(Channels) : 1;

    kes_state_e state, state_nxt;

    logic [Channels-1:0]    pending, pending_nxt, ready_q;
    logic [Channels-1:0]    ch_end, capture, eligible, end_vec;
    logic [SynW-1:0]        syn_buf [Channels];
    logic [BCHDecMulti-1:0] dn_buf  [Channels];
    logic [IdxW-1:0]        rr_ptr, owner;

    logic [Channels-1:0]    arb_gnt;
    logic [IdxW-1:0]        arb_idx;
    logic                   arb_vld;

    logic                   grant, res_clear, res_load, ret_done;

    logic [BCHDecMulti-1:0] res_err, res_fail;
    logic [CntW-1:0]        res_cnt;
    logic [ElpW-1:0]        res_elp;

    // A request is eligible when it can make progress right now: fast-path
    // requests always can, KES requests only while the KES is idle. This lets
    // a zero-work request bypass a KES request stalled on a busy engine.
    always_comb begin
        ch_end   = '0;
        eligible = '0;
        for (int c = 0; c < Channels; c++) begin
            ch_end[c]   = |iChErrorDetectionEnd[c*BCHDecMulti +: BCHDecMulti];
            eligible[c] = pending[c] & ((dn_buf[c] == '0) | iKESReady);
        end
    end

    // An end pulse on a channel that is still pending is dropped.
    assign capture = ch_end & ~pending;

    bch_rr_arbiter #(
        .N  (Channels),
        .IW (IdxW)
    ) u_arb (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        res_clear = 1'b0;
        res_load  = 1'b0;
        ret_done  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    grant = 1'b1;
                    if (dn_buf[arb_idx] == '0) begin
                        res_clear = 1'b1;
                        state_nxt = RETURN;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (iKESDone) begin
                    res_load  = 1'b1;
                    state_nxt = RETURN;
                end
            end
            RETURN: begin
                if (iChCSAvailable[owner]) begin
                    ret_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        end_vec = '0;
        if (ret_done) begin
            end_vec[owner] = 1'b1;
        end
    end

    assign pending_nxt = (pending | capture) & ~end_vec;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            pending <= '0;
            ready_q <= '1;
            rr_ptr  <= '0;
            owner   <= '0;
            for (int c = 0; c < Channels; c++) begin
                syn_buf[c] <= '0;
                dn_buf[c]  <= '0;
            end
        end else begin
            pending <= pending_nxt;
            ready_q <= ~pending_nxt;
            for (int c = 0; c < Channels; c++) begin
                if (capture[c]) begin
                    syn_buf[c] <= iChSyndromes[c*SynW +: SynW];
                    dn_buf[c]  <= iChDecodeNeeded[c*BCHDecMulti +: BCHDecMulti];
                end
            end
            if (grant) begin
                owner  <= arb_idx;
                rr_ptr <= (arb_idx == IdxW'(Channels - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            res_err  <= '0;
            res_fail <= '0;
            res_cnt  <= '0;
            res_elp  <= '0;
        end else if (res_clear) begin
            res_err  <= '0;
            res_fail <= '0;
            res_cnt  <= '0;
            res_elp  <= '0;
        end else if (res_load) begin
            res_err  <= iKESErroredChunk;
            res_fail <= iKESCorrectionFail;
            res_cnt  <= iKESErrorCount;
            res_elp  <= iKESELPCoefficients;
        end
    end

    always @(posedge iClock) begin
        if (!iReset) begin
            for (int c = 0; c < Channels; c++) begin
                assert (!(ch_end[c] && pending[c]))
                    else $warning("protocol violation: end pulse on pending channel %0d ignored", c);
            end
        end
    end

    assign oChSharedKESReady    = ready_q;
    assign oChIntraSharedKESEnd = end_vec;
    assign oChErroredChunk      = {Channels{res_err}};
    assign oChCorrectionFail    = {Channels{res_fail}};
    assign oChErrorCount        = {Channels{res_cnt}};
    assign oChELPCoefficients   = {Channels{res_elp}};

    assign oBusy            = (state != IDLE);
    assign oKESStart        = (state == ISSUE);
    assign oKESSyndromes    = oBusy ? syn_buf[owner] : '0;
    assign oKESDecodeNeeded = oBusy ? dn_buf[owner]  : '0;

endmodule

// File: tb/tb_bch_shared_kes_dispatcher.sv
module tb_bch_shared_kes_dispatcher;

    localparam int CH   = 4;
    localparam int M    = 2;
    localparam int SYNW = 648;
    localparam int ELPW = 360;
    localparam int CNTW = 18;

    logic                 iClock;
    logic                 iReset;
    logic [CH*M-1:0]      iChErrorDetectionEnd;
    logic [CH*M-1:0]      iChDecodeNeeded;
    logic [CH*SYNW-1:0]   iChSyndromes;
    logic [CH-1:0]        oChSharedKESReady;
    logic [CH-1:0]        iChCSAvailable;
    logic [CH-1:0]        oChIntraSharedKESEnd;
    logic [CH*M-1:0]      oChErroredChunk;
    logic [CH*M-1:0]      oChCorrectionFail;
    logic [CH*CNTW-1:0]   oChErrorCount;
    logic [CH*ELPW-1:0]   oChELPCoefficients;
    logic                 oKESStart;
    logic [M-1:0]         oKESDecodeNeeded;
    logic [SYNW-1:0]      oKESSyndromes;
    logic                 iKESReady;
    logic                 iKESDone;
    logic [M-1:0]         iKESErroredChunk;
    logic [M-1:0]         iKESCorrectionFail;
    logic [CNTW-1:0]      iKESErrorCount;
    logic [ELPW-1:0]      iKESELPCoefficients;
    logic                 oBusy;

    int total = 0;
    int bad   = 0;

    bch_shared_kes_dispatcher dut (
        .iClock               (iClock),
        .iReset               (iReset),
        .iChErrorDetectionEnd (iChErrorDetectionEnd),
        .iChDecodeNeeded      (iChDecodeNeeded),
        .iChSyndromes         (iChSyndromes),
        .oChSharedKESReady    (oChSharedKESReady),
        .iChCSAvailable       (iChCSAvailable),
        .oChIntraSharedKESEnd (oChIntraSharedKESEnd),
        .oChErroredChunk      (oChErroredChunk),
        .oChCorrectionFail    (oChCorrectionFail),
        .oChErrorCount        (oChErrorCount),
        .oChELPCoefficients   (oChELPCoefficients),
        .oKESStart            (oKESStart),
        .oKESDecodeNeeded     (oKESDecodeNeeded),
        .oKESSyndromes        (oKESSyndromes),
        .iKESReady            (iKESReady),
        .iKESDone             (iKESDone),
        .iKESErroredChunk     (iKESErroredChunk),
        .iKESCorrectionFail   (iKESCorrectionFail),
        .iKESErrorCount       (iKESErrorCount),
        .iKESELPCoefficients  (iKESELPCoefficients),
        .oBusy                (oBusy)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are sampled one more time unit later.
    task automatic cyc();
        @(posedge iClock);
        #1;
    endtask

    task automatic pulse(input int c, input logic [1:0] dn, input logic [63:0] pat);
        iChErrorDetectionEnd[c*M +: M] = 2'b11;
        iChDecodeNeeded[c*M +: M]      = dn;
        iChSyndromes[c*SYNW +: 64]     = pat;
    endtask

    initial begin
        int n;
        int ch;
        iReset               = 1'b1;
        iChErrorDetectionEnd = '0;
        iChDecodeNeeded      = '0;
        iChSyndromes         = '0;
        iChCSAvailable       = '1;
        iKESReady            = 1'b1;
        iKESDone             = 1'b0;
        iKESErroredChunk     = '0;
        iKESCorrectionFail   = '0;
        iKESErrorCount       = '0;
        iKESELPCoefficients  = '0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_ready", 64'(oChSharedKESReady), 64'hF);
        chk("rst_busy",  64'(oBusy), 0);
        chk("rst_start", 64'(oKESStart), 0);
        chk("rst_end",   64'(oChIntraSharedKESEnd), 0);
        chk("rst_cnt",   64'(oChErrorCount[63:0]), 0);
        cyc();
        iReset = 1'b0;

        // Single request through the KES: ch1, DecodeNeeded=01
        cyc();
        pulse(1, 2'b01, 64'h0123_4567_89AB_CDEF);
        #1;
        cyc();
        iChErrorDetectionEnd = '0;
        #1;
        chk("kes_ready_low", 64'(oChSharedKESReady), 64'hD);
        chk("kes_c1_idle",   64'(oBusy), 0);
        cyc(); #1;
        chk("kes_start",     64'(oKESStart), 1);
        chk("kes_dn",        64'(oKESDecodeNeeded), 64'h1);
        chk("kes_syn",       oKESSyndromes[63:0], 64'h0123_4567_89AB_CDEF);
        for (int i = 3; i <= 11; i++) begin
            cyc(); #1;
        end
        chk("kes_start_once", 64'(oKESStart), 0);
        cyc();
        iKESDone            = 1'b1;
        iKESErroredChunk    = 2'b01;
        iKESErrorCount      = 18'd3;
        iKESELPCoefficients = 360'h5A5A_1234;
        #1;
        chk("kes_end_wait",  64'(oChIntraSharedKESEnd), 0);
        cyc();
        iKESDone = 1'b0;
        #1;
        chk("kes_end",       64'(oChIntraSharedKESEnd), 64'h2);
        chk("kes_cnt_ch1",   64'(oChErrorCount[1*CNTW +: CNTW]), 3);
        chk("kes_cnt_ch3",   64'(oChErrorCount[3*CNTW +: CNTW]), 3);
        chk("kes_errchunk",  64'(oChErroredChunk), 64'h55);
        chk("kes_fail",      64'(oChCorrectionFail), 0);
        chk("kes_elp",       oChELPCoefficients[1*ELPW +: 64], 64'h5A5A_1234);
        chk("kes_ready_end", 64'(oChSharedKESReady), 64'hD);
        cyc(); #1;
        chk("kes_ready_back", 64'(oChSharedKESReady), 64'hF);
        chk("kes_end_gone",   64'(oChIntraSharedKESEnd), 0);
        chk("kes_idle",       64'(oBusy), 0);

        // Fast path on ch0 while the KES is busy
        cyc();
        iKESReady = 1'b0;
        pulse(0, 2'b00, 64'h0);
        #1;
        cyc();
        iChErrorDetectionEnd = '0;
        #1;
        chk("fast_c1_start", 64'(oKESStart), 0);
        chk("fast_c1_ready", 64'(oChSharedKESReady), 64'hE);
        cyc(); #1;
        chk("fast_end",      64'(oChIntraSharedKESEnd), 64'h1);
        chk("fast_start",    64'(oKESStart), 0);
        chk("fast_cnt",      64'(oChErrorCount[CNTW-1:0]), 0);
        chk("fast_errchunk", 64'(oChErroredChunk), 0);
        chk("fast_elp",      oChELPCoefficients[63:0], 0);
        cyc(); #1;
        chk("fast_ready",    64'(oChSharedKESReady), 64'hF);

        // Second fast path on ch1 moves the pointer to channel 2
        cyc();
        pulse(1, 2'b00, 64'h0);
        #1;
        cyc();
        iChErrorDetectionEnd = '0;
        #1;
        cyc(); #1;
        chk("fast2_end", 64'(oChIntraSharedKESEnd), 64'h2);
        cyc();
        iKESReady = 1'b1;
        #1;
        chk("fast2_ready", 64'(oChSharedKESReady), 64'hF);

        // Fairness: all channels request together, expected order 2,3,0,1
        cyc();
        for (int c = 0; c < CH; c++) pulse(c, 2'b10, 64'(c + 64'hC0DE_0000));
        #1;
        cyc();
        iChErrorDetectionEnd = '0;
        #1;
        chk("fair_ready_low", 64'(oChSharedKESReady), 0);
        for (int k = 0; k < CH; k++) begin
            ch = (2 + k) % CH;
            n = 0;
            while (oKESStart !== 1'b1 && n < 10) begin
                cyc(); #1;
                n++;
            end
            chk("fair_start", 64'(oKESStart), 1);
            chk("fair_syn",   oKESSyndromes[63:0], 64'(ch + 64'hC0DE_0000));
            chk("fair_dn",    64'(oKESDecodeNeeded), 64'h2);
            cyc();
            iKESDone         = 1'b1;
            iKESErroredChunk = 2'b01;
            iKESErrorCount   = 18'(10 + ch);
            if (ch == 3) iChCSAvailable = 4'b0111;
            #1;
            chk("fair_end_wait", 64'(oChIntraSharedKESEnd), 0);
            cyc();
            iKESDone = 1'b0;
            #1;
            if (ch == 3) begin
                for (int i = 0; i < 20; i++) begin
                    chk("bp_no_end",   64'(oChIntraSharedKESEnd), 0);
                    chk("bp_no_start", 64'(oKESStart), 0);
                    cyc(); #1;
                end
                iChCSAvailable = '1;
                #1;
            end
            chk("fair_end", 64'(oChIntraSharedKESEnd), 64'(4'b0001 << ch));
            chk("fair_cnt", 64'(oChErrorCount[ch*CNTW +: CNTW]), 64'(10 + ch));
            cyc(); #1;
            chk("fair_ready", 64'(oChSharedKESReady[ch]), 1);
        end

        // Protocol violation: second pulse on a pending ch2 is dropped
        cyc();
        iKESReady = 1'b0;
        pulse(2, 2'b01, 64'hAAAA_0001);
        #1;
        cyc();
        pulse(2, 2'b10, 64'hBBBB_0002);
        #1;
        chk("viol_ready", 64'(oChSharedKESReady), 64'hB);
        chk("viol_idle",  64'(oBusy), 0);
        cyc();
        iChErrorDetectionEnd = '0;
        iKESReady = 1'b1;
        #1;
        n = 0;
        while (oKESStart !== 1'b1 && n < 10) begin
            cyc(); #1;
            n++;
        end
        chk("viol_start", 64'(oKESStart), 1);
        chk("viol_dn",    64'(oKESDecodeNeeded), 64'h1);
        chk("viol_syn",   oKESSyndromes[63:0], 64'hAAAA_0001);

        // Asynchronous reset in WAIT abandons the transaction
        cyc(); #1;
        chk("rstw_busy_pre", 64'(oBusy), 1);
        iReset = 1'b1;
        #1;
        chk("rstw_busy",  64'(oBusy), 0);
        chk("rstw_ready", 64'(oChSharedKESReady), 64'hF);
        chk("rstw_dn",    64'(oKESDecodeNeeded), 0);
        chk("rstw_syn",   oKESSyndromes[63:0], 0);
        chk("rstw_cnt",   64'(oChErrorCount[CNTW-1:0]), 0);
        cyc();
        iReset = 1'b0;
        cyc();
        iKESDone = 1'b1;
        #1;
        chk("late_done_end", 64'(oChIntraSharedKESEnd), 0);
        cyc();
        iKESDone = 1'b0;
        #1;
        chk("late_done_end2",  64'(oChIntraSharedKESEnd), 0);
        chk("late_done_busy",  64'(oBusy), 0);
        chk("late_done_ready", 64'(oChSharedKESReady), 64'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
